sea_byte_io: RTL and testbench

Byte-serial front/back end for the 96-bit SEA cipher datapath on the TinyTapeout pin budget. Accepts 18 bytes over an 8-bit valid/ready input stream and assembles them into the 48-bit `li`, `ri` and `ki` words that feed the encrypt→decrypt core. After a fixed core latency it captures the core's 48-bit `lio`/`rio` result and returns it as 12 bytes on an 8-bit valid/ready output stream. It sits between the chip pins and the cipher core, directly upstream (operand feed) and downstream (result drain) of it.

---
 rtl/sea_pkg.sv | 15 +
 rtl/sea_byte_shifter.sv | 29 ++
 rtl/sea_byte_io.sv | 127 ++++++++++++
 tb/tb_sea_byte_io.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sea_pkg.sv
// Shared definitions for the SEA byte-serial I/O wrapper: FSM encoding and
// the cipher word/frame geometry.
package sea_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WAIT   = 2'd1,
        UNLOAD = 2'd2
    } sea_state_t;

    localparam int SEA_HALF_W    = 48;
    localparam int SEA_BLK_BYTES = 18;
    localparam int SEA_RES_BYTES = 12;

endpackage

// File: rtl/sea_byte_shifter.sv
// 96-bit result register: parallel load from the cipher core, then drained
// MSB byte first by shifting left one byte per output handshake.
module sea_byte_shifter
    import sea_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    shift,
    input  logic [2*SEA_HALF_W-1:0] d,
    output logic [7:0]              q_top
);

    logic [2*SEA_HALF_W-1:0] sreg;

    // Load has priority; the FSM never asks for both in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= d;
        end else if (shift) begin
            sreg <= {sreg[2*SEA_HALF_W-9:0], 8'h00};
        end
    end

    assign q_top = sreg[2*SEA_HALF_W-1 -: 8];

endmodule

// File: rtl/sea_byte_io.sv
// Byte-serial operand feed and result drain around the SEA cipher core:
// 18 bytes in to li/ri/ki, fixed-latency wait, 12 bytes of lio/rio out.
module sea_byte_io
    import sea_pkg::*;
#(
    parameter int unsigned CIPHER_LAT = 3
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEA_HALF_W-1:0] li,
    output logic [SEA_HALF_W-1:0] ri,
    output logic [SEA_HALF_W-1:0] ki,
    input  logic [SEA_HALF_W-1:0] lio,
    input  logic [SEA_HALF_W-1:0] rio,
    output logic                  busy
);

    sea_state_t state;
    sea_state_t state_next;

    logic [4:0]              byte_cnt;
    logic [3:0]              wait_cnt;
    logic [3*SEA_HALF_W-1:0] opnd;

    logic in_hs;
    logic out_hs;
    logic last_in;
    logic wait_done;
    logic last_out;

    // Every event qualifier already includes ena, so a low ena freezes all state.
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready & ena;
    assign last_in   = in_hs && (byte_cnt == 5'(SEA_BLK_BYTES - 1));
    assign wait_done = (state == WAIT) && ena && (wait_cnt == 4'd1);
    assign last_out  = out_hs && (byte_cnt == 5'(SEA_RES_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (last_in)   state_next = WAIT;
            WAIT:    if (wait_done) state_next = UNLOAD;
            UNLOAD:  if (last_out)  state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // in_ready is forced low while reset is held, not just after the first edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD:    in_ready = ena & rst_n;
            WAIT:    busy = 1'b1;
            UNLOAD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // byte_cnt is shared: input byte index in LOAD, output byte index in UNLOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (last_in || wait_done || last_out) begin
            byte_cnt <= '0;
        end else if (in_hs || out_hs) begin
            byte_cnt <= byte_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (last_in) begin
            wait_cnt <= 4'(CIPHER_LAT);
        end else if ((state == WAIT) && ena && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Byte 0 lands in the top byte of li, byte 17 in the bottom byte of ki.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd <= '0;
        end else if (in_hs) begin
            for (int i = 0; i < SEA_BLK_BYTES; i++) begin
                if (byte_cnt == 5'(i)) begin
                    opnd[8*(SEA_BLK_BYTES-1-i) +: 8] <= in_byte;
                end
            end
        end
    end

    assign li = opnd[3*SEA_HALF_W-1 -: SEA_HALF_W];
    assign ri = opnd[2*SEA_HALF_W-1 -: SEA_HALF_W];
    assign ki = opnd[SEA_HALF_W-1:0];

    sea_byte_shifter u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (wait_done),
        .shift (out_hs),
        .d     ({lio, rio}),
        .q_top (out_byte)
    );

endmodule

// File: tb/tb_sea_byte_io.sv
// Self-checking bench for sea_byte_io: table of frames with a XOR core model,
// plus hand-written reset and enable-hold sequences.
module tb_sea_byte_io;
    import sea_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] li;
    logic [47:0] ri;
    logic [47:0] ki;
    logic [47:0] lio;
    logic [47:0] rio;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [143:0] frame;
        logic [47:0]  exp_li;
        logic [47:0]  exp_ri;
        logic [47:0]  exp_ki;
        logic [95:0]  exp_res;
        int           load_hold;
        int           wait_hold;
        int           stall;
    } vec_t;

    vec_t vecs [4];

    sea_byte_io #(.CIPHER_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .li        (li),
        .ri        (ri),
        .ki        (ki),
        .lio       (lio),
        .rio       (rio),
        .busy      (busy)
    );

    // Stand-in cipher core: combinational, so the DUT's own wait sets the latency.
    assign lio = li ^ ki;
    assign rio = ri ^ ki;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int idx   = 0;
        int slots = 0;
        int hold  = 0;
        int k     = 0;
        int guard = 0;

        while (idx < SEA_BLK_BYTES && slots < 100) begin
            @(negedge clk);
            slots++;
            if (idx == 8 && hold < v.load_hold) begin
                ena = 1'b0;
                hold++;
            end else begin
                ena = 1'b1;
            end
            in_valid = 1'b1;
            in_byte  = v.frame[143 - 8*idx -: 8];
            #1;
            if (!ena) checkOutput("in_ready with ena low", 96'(in_ready), 96'(0));
            if (in_ready) begin
                if (idx == SEA_BLK_BYTES - 1) checkOutput("busy before last byte", 96'(busy), 96'(0));
                idx++;
            end
        end
        checkOutput("load cycles", 96'(slots), 96'(SEA_BLK_BYTES + v.load_hold));

        @(negedge clk);
        checkOutput("busy after last byte", 96'(busy), 96'(1));
        checkOutput("li", 96'(li), 96'(v.exp_li));
        checkOutput("ri", 96'(ri), 96'(v.exp_ri));
        checkOutput("ki", 96'(ki), 96'(v.exp_ki));

        k = 0;
        while (!out_valid && k < 60) begin
            ena = !(k >= 1 && k < 1 + v.wait_hold);
            #1;
            checkOutput("in_ready in WAIT", 96'(in_ready), 96'(0));
            @(negedge clk);
            k++;
        end
        ena = 1'b1;
        checkOutput("result latency", 96'(k), 96'(LAT + v.wait_hold));

        idx   = 0;
        guard = 0;
        while (idx < SEA_RES_BYTES && guard < 100) begin
            checkOutput("out_valid in UNLOAD", 96'(out_valid), 96'(1));
            checkOutput($sformatf("out_byte %0d", idx), 96'(out_byte), 96'(v.exp_res[95 - 8*idx -: 8]));
            checkOutput("in_ready in UNLOAD", 96'(in_ready), 96'(0));
            out_ready = (v.stall == 0) || (guard % 3 == 2);
            if (out_ready) begin
                idx++;
                if (idx == SEA_RES_BYTES) in_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        checkOutput("drain cycles", 96'(guard), 96'((v.stall != 0) ? 3*SEA_RES_BYTES : SEA_RES_BYTES));
        checkOutput("busy after drain", 96'(busy), 96'(0));
        checkOutput("out_valid after drain", 96'(out_valid), 96'(0));
        checkOutput("in_ready after drain", 96'(in_ready), 96'(1));
        checkOutput("li after drain", 96'(li), 96'(v.exp_li));
        checkOutput("ki after drain", 96'(ki), 96'(v.exp_ki));
    endtask

    initial begin
        vecs[0] = '{144'h0102030405060708090A0B0C0D0E0F101112,
                    48'h010203040506, 48'h0708090A0B0C, 48'h0D0E0F101112,
                    96'h0C0C0C1414140A06061A1A1E, 0, 0, 0};
        vecs[1] = '{144'hFFFFFFFFFFFF000000000000A5A5A5A5A5A5,
                    48'hFFFFFFFFFFFF, 48'h000000000000, 48'hA5A5A5A5A5A5,
                    96'h5A5A5A5A5A5AA5A5A5A5A5A5, 0, 0, 1};
        vecs[2] = '{144'h123456789ABCDEF01234567800000000FF00,
                    48'h123456789ABC, 48'hDEF012345678, 48'h00000000FF00,
                    96'h1234567865BCDEF01234A978, 5, 5, 0};
        vecs[3] = '{144'h2122232425262728292A2B2C2D2E2F303132,
                    48'h212223242526, 48'h2728292A2B2C, 48'h2D2E2F303132,
                    96'h0C0C0C1414140A06061A1A1E, 0, 0, 0};

        rst_n     = 1'b0;
        ena       = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;

        #12;
        checkOutput("reset li", 96'(li), 96'(0));
        checkOutput("reset ki", 96'(ki), 96'(0));
        checkOutput("reset busy", 96'(busy), 96'(0));
        checkOutput("reset out_valid", 96'(out_valid), 96'(0));
        checkOutput("reset out_byte", 96'(out_byte), 96'(0));
        ena = 1'b1;
        #1;
        checkOutput("in_ready held in reset", 96'(in_ready), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready after reset", 96'(in_ready), 96'(1));

        for (int v = 0; v < 3; v++) applyStimulus(vecs[v]);

        // Partial frame of 11 bytes, then an asynchronous abort mid-cycle.
        begin
            int idx   = 0;
            int guard = 0;
            while (idx < 11 && guard < 50) begin
                @(negedge clk);
                guard++;
                ena      = 1'b1;
                in_valid = 1'b1;
                in_byte  = vecs[2].frame[143 - 8*idx -: 8];
                #1;
                if (in_ready) idx++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("partial li loaded", 96'(li), 96'(vecs[2].exp_li));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset li", 96'(li), 96'(0));
        checkOutput("async reset ri", 96'(ri), 96'(0));
        checkOutput("async reset busy", 96'(busy), 96'(0));
        checkOutput("async reset in_ready", 96'(in_ready), 96'(0));
        checkOutput("async reset out_byte", 96'(out_byte), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(vecs[3]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
